// File: rtl/grayscale_stream_if.sv
// grayscale_stream_if: handshake bundle between the core and its two FIFOs
//   in_dout   FWFT input word {B,G,R}      in_empty  input FIFO empty
//   in_rd_en  pop input FIFO               out_din   gray word to output FIFO
//   out_full  output FIFO full             out_wr_en push output FIFO
//   master = FIFO side, slave = grayscale core
interface grayscale_stream_if #(parameter int CH_WIDTH = 8);
  logic [3*CH_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [3*CH_WIDTH-1:0] out_din;
  logic                  out_full;
  logic                  out_wr_en;
  modport master (output in_dout, in_empty, out_full, input in_rd_en, out_din, out_wr_en);
  modport slave (input in_dout, in_empty, out_full, output in_rd_en, out_din, out_wr_en);
endinterface

// File: rtl/grayscale_stream.sv
// grayscale_stream: 2-stage streaming RGB->gray converter between FWFT input and output FIFOs
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   enable      1 = may pop new pixels, 0 = stop popping and let the pipeline drain
//   mode        0 = luma weights (R77,G150,B29), 1 = average (R85,G86,B85), latched per frame
//   fifo        FIFO handshake bundle (slave side)
//   frame_done  1-cycle pulse after the push of a frame's last pixel
//   busy        any pipeline stage holds valid data
module grayscale_stream #(
  parameter int CH_WIDTH     = 8,
  parameter int FRAME_PIXELS = 388800,
  parameter int CNT_WIDTH    = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  grayscale_stream_if.slave  fifo,
  output logic               frame_done,
  output logic               busy
);
  localparam int PW = CH_WIDTH + 8;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_PIXELS - 1);
  logic                 s1_valid_q, s2_valid_q, mode_q, frame_done_q;
  logic                 advance, cur_mode;
  logic [7:0]           wb, wg, wr;
  logic [PW-1:0]        pb_q, pg_q, pr_q, pb_d, pg_d, pr_d;
  logic [CH_WIDTH-1:0]  gray_q, gray_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  assign advance        = !s2_valid_q || !fifo.out_full;
  assign fifo.in_rd_en  = reset && enable && !fifo.in_empty && advance;
  assign fifo.out_wr_en = s2_valid_q && !fifo.out_full;
  assign fifo.out_din   = {3{gray_q}};
  assign frame_done     = frame_done_q;
  assign busy           = s1_valid_q || s2_valid_q;
  // The first pop of a frame takes mode live; the rest of the frame uses the latched copy.
  // Weights are applied at stage 1, so the mode travels with the products.
  assign cur_mode = (in_cnt_q == '0) ? mode : mode_q;
  always_comb begin
    wr        = cur_mode ? 8'd85 : 8'd77;
    wg        = cur_mode ? 8'd86 : 8'd150;
    wb        = cur_mode ? 8'd85 : 8'd29;
    pb_d      = PW'(fifo.in_dout[3*CH_WIDTH-1:2*CH_WIDTH]) * PW'(wb);
    pg_d      = PW'(fifo.in_dout[2*CH_WIDTH-1:CH_WIDTH]) * PW'(wg);
    pr_d      = PW'(fifo.in_dout[CH_WIDTH-1:0]) * PW'(wr);
    // Weights sum to 256, so the weighted sum fits PW bits and >>8 never exceeds the channel range.
    gray_d    = CH_WIDTH'((pb_q + pg_q + pr_q) >> 8);
    in_cnt_d  = fifo.in_rd_en ? ((in_cnt_q == LAST) ? '0 : in_cnt_q + 1'b1) : in_cnt_q;
    out_cnt_d = fifo.out_wr_en ? ((out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1) : out_cnt_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      mode_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pb_q         <= '0;
      pg_q         <= '0;
      pr_q         <= '0;
      gray_q       <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_done_q <= fifo.out_wr_en && (out_cnt_q == LAST);
      if (fifo.in_rd_en && in_cnt_q == '0) mode_q <= mode;
      if (advance) begin
        s1_valid_q <= fifo.in_rd_en;
        pb_q       <= pb_d;
        pg_q       <= pg_d;
        pr_q       <= pr_d;
        s2_valid_q <= s1_valid_q;
        gray_q     <= gray_d;
      end
    end
  end
endmodule

// File: tb/tb_grayscale_stream.sv
// tb_grayscale_stream: directed + random stimulus against a frame-level reference model
module tb_grayscale_stream;
  localparam int F = 4;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, mode = 1'b0;
  logic frame_done, busy;
  grayscale_stream_if #(.CH_WIDTH(8)) bus();
  grayscale_stream #(.CH_WIDTH(8), .FRAME_PIXELS(F), .CNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .fifo(bus), .frame_done(frame_done), .busy(busy)
  );
  always #5 clock = ~clock;
  logic [23:0] src[$], stage[$], exp_q[$], obs_q[$];
  int pop_cyc[$];
  int tests = 0, fails = 0, cyc = 0, in_n = 0, out_n = 0, pushes = 0, pops = 0, fd_cnt = 0;
  int last_lat = 0, p0, f0;
  logic lmode = 1'b0, exp_fd = 1'b0;
  logic [23:0] last_out = '0;
  function automatic logic [23:0] gray(logic [23:0] p, logic m);
    int r = int'(p[7:0]);
    int g = int'(p[15:8]);
    int b = int'(p[23:16]);
    int v = m ? (85*r + 86*g + 85*b) / 256 : (77*r + 150*g + 29*b) / 256;
    return {3{v[7:0]}};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic [23:0] px;
    @(negedge clock);
    bus.in_empty = (src.size() == 0);
    bus.in_dout  = (src.size() != 0) ? src[0] : 24'h0;
    #1;
    chk("frame_done", frame_done, exp_fd);
    chk("busy", busy, exp_q.size() != 0);
    if (frame_done === 1'b1) fd_cnt++;
    if (bus.out_full) chk("no_push_when_full", bus.out_wr_en, 0);
    if (bus.out_full && exp_q.size() == 2) chk("no_pop_when_stalled", bus.in_rd_en, 0);
    if (!enable) chk("no_pop_when_disabled", bus.in_rd_en, 0);
    if (src.size() == 0) chk("no_pop_when_empty", bus.in_rd_en, 0);
    exp_fd = 1'b0;
    if (bus.out_wr_en === 1'b1) begin
      chk("push_has_data", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("out_din", bus.out_din, exp_q[0]);
        last_out = bus.out_din;
        last_lat = cyc - pop_cyc[0];
        obs_q.push_back(bus.out_din);
        void'(exp_q.pop_front());
        void'(pop_cyc.pop_front());
      end
      exp_fd = (out_n == F - 1);
      out_n  = (out_n + 1) % F;
      pushes++;
    end
    if (bus.in_rd_en === 1'b1 && src.size() != 0) begin
      px = src.pop_front();
      if (in_n == 0) lmode = mode;
      exp_q.push_back(gray(px, lmode));
      pop_cyc.push_back(cyc);
      in_n = (in_n + 1) % F;
      pops++;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.in_empty = 1'b1;
    #1;
    chk("rst_rd_en", bus.in_rd_en, 0);
    chk("rst_wr_en", bus.out_wr_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_din", bus.out_din, 0);
    src.delete(); exp_q.delete(); pop_cyc.delete(); obs_q.delete();
    in_n = 0; out_n = 0; lmode = 1'b0; exp_fd = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic send_one(logic [23:0] pix, logic [23:0] exp);
    int p = pushes;
    src.push_back(pix);
    for (int i = 0; i < 10 && pushes == p; i++) step();
    chk("single_push_seen", pushes - p, 1);
    chk("single_gray", last_out, exp);
    chk("single_latency", last_lat, 2);
  endtask
  initial begin
    bus.in_dout = '0; bus.in_empty = 1'b1; bus.out_full = 1'b0;
    do_reset();
    enable = 1'b1;
    mode = 1'b0;
    send_one(24'hFFFFFF, 24'hFFFFFF);
    send_one(24'h0000FF, 24'h4C4C4C);
    send_one(24'h000000, 24'h000000);
    send_one(24'h0000FF, 24'h4C4C4C);
    mode = 1'b1;
    send_one(24'h0000FF, 24'h545454);
    p0 = pushes;
    for (int i = 0; i < 64; i++) stage.push_back(24'($urandom));
    for (int i = 0; i < 400 && pushes - p0 < 64; i++) begin
      if (stage.size() != 0 && $urandom_range(0, 3) != 0) src.push_back(stage.pop_front());
      bus.out_full = (i >= 20 && i < 25);
      enable = !(i >= 40 && i < 43);
      mode = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_full = 1'b0; enable = 1'b1;
    chk("stream_count", pushes - p0, 64);
    chk("stream_drained", exp_q.size(), 0);
    do_reset();
    mode = 1'b0; p0 = pushes; f0 = fd_cnt;
    for (int i = 0; i < 8; i++) src.push_back(24'($urandom));
    for (int i = 0; i < 40 && pushes - p0 < 8; i++) step();
    step(); step();
    chk("frame_count_pushes", pushes - p0, 8);
    chk("frame_done_pulses", fd_cnt - f0, 2);
    do_reset();
    mode = 1'b0; p0 = pops;
    for (int i = 0; i < 8; i++) src.push_back(24'h0000FF);
    for (int i = 0; i < 40 && obs_q.size() < 8; i++) begin
      if (pops - p0 >= 2) mode = 1'b1;
      step();
    end
    chk("mode_frame_count", obs_q.size(), 8);
    for (int k = 0; k < obs_q.size(); k++)
      chk("mode_frame_value", obs_q[k], (k < 4) ? 24'h4C4C4C : 24'h545454);
    do_reset();
    mode = 1'b0;
    src.push_back(24'h123456); src.push_back(24'h654321);
    step(); step();
    chk("inflight_busy", busy, 1);
    do_reset();
    mode = 1'b1; p0 = pushes; f0 = fd_cnt;
    for (int i = 0; i < 4; i++) src.push_back(24'h0000FF);
    for (int i = 0; i < 30 && pushes - p0 < 4; i++) step();
    step(); step();
    chk("post_reset_pushes", pushes - p0, 4);
    chk("post_reset_frame_done", fd_cnt - f0, 1);
    for (int k = 0; k < obs_q.size(); k++) chk("post_reset_mode", obs_q[k], 24'h545454);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
